// File: rtl/nnrv_pkg.sv
// nnrv_pkg: shared types and constants for the data-RAM arbiter.
package nnrv_pkg;
  typedef enum logic [1:0] {OWN_IDLE, OWN_IF, OWN_MEM} owner_e;
  localparam int STARVE_MAX_DEF = 4;
  localparam logic [3:0] FULL_MASK = 4'b1111;
endpackage

// File: rtl/nnrv_starve_cnt.sv
// nnrv_starve_cnt: saturating counter of consecutive IF-denied cycles.
module nnrv_starve_cnt #(
  parameter int CNT_W = 3,
  parameter int MAX   = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  logic [CNT_W-1:0] r_cnt;
  assign o_sat = r_cnt == CNT_W'(MAX);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_sat) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/nnrv_ram_arb.sv
// nnrv_ram_arb: shares the single-port data RAM between IF and MEM,
// with one-cycle read response routing and IF anti-starvation.
module nnrv_ram_arb import nnrv_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  output logic            o_if_stall,
  input  logic            i_mem_req,
  input  logic            i_mem_we,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [3:0]      i_mem_mask,
  input  logic [XLEN-1:0] i_mem_wdata,
  output logic            o_mem_gnt,
  output logic            o_mem_rvalid,
  output logic [XLEN-1:0] o_mem_rdata,
  output logic            o_mem_stall,
  output logic            o_ram_en,
  output logic            o_ram_we,
  output logic [XLEN-1:0] o_ram_addr,
  output logic [3:0]      o_ram_mask,
  output logic [XLEN-1:0] o_ram_wdata,
  input  logic [XLEN-1:0] i_ram_rdata
);
  logic   w_sat, w_if_deny, w_mem_acc;
  owner_e r_state;
  nnrv_starve_cnt #(.CNT_W(CNT_W), .MAX(STARVE_MAX)) u_starve (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_if_deny),
    .i_clr   (~w_if_deny),
    .o_sat   (w_sat)
  );
  assign o_if_gnt    = i_if_req & (~i_mem_req | w_sat);
  assign o_mem_gnt   = i_mem_req & ~o_if_gnt;
  assign w_if_deny   = i_if_req & ~o_if_gnt;
  assign o_if_stall  = w_if_deny;
  assign o_mem_stall = i_mem_req & ~o_mem_gnt;
  // an all-zero-mask store completes its handshake without touching the RAM
  assign w_mem_acc   = o_mem_gnt & ~(i_mem_we & (i_mem_mask == 4'b0000));
  assign o_ram_en    = o_if_gnt | w_mem_acc;
  assign o_ram_we    = w_mem_acc & i_mem_we;
  assign o_ram_addr  = o_if_gnt ? i_if_addr : w_mem_acc ? i_mem_addr : '0;
  assign o_ram_mask  = o_if_gnt ? FULL_MASK : w_mem_acc ? i_mem_mask : 4'b0000;
  assign o_ram_wdata = w_mem_acc ? i_mem_wdata : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= OWN_IDLE;
    else r_state <= o_if_gnt ? OWN_IF : (o_mem_gnt && !i_mem_we) ? OWN_MEM : OWN_IDLE;
  assign o_if_rvalid  = r_state == OWN_IF;
  assign o_mem_rvalid = r_state == OWN_MEM;
  assign o_if_rdata   = o_if_rvalid ? i_ram_rdata : '0;
  assign o_mem_rdata  = o_mem_rvalid ? i_ram_rdata : '0;
endmodule

// File: tb/tb_nnrv_ram_arb.sv
// tb_nnrv_ram_arb: directed vectors for the data-RAM arbiter.
module tb_nnrv_ram_arb;
  logic        i_clk = 0, i_rst_n = 0;
  logic        i_if_req = 0, i_mem_req = 0, i_mem_we = 0;
  logic [31:0] i_if_addr = 0, i_mem_addr = 0, i_mem_wdata = 0, i_ram_rdata = 0;
  logic [3:0]  i_mem_mask = 0;
  logic        o_if_gnt, o_if_rvalid, o_if_stall, o_mem_gnt, o_mem_rvalid, o_mem_stall;
  logic        o_ram_en, o_ram_we;
  logic [31:0] o_if_rdata, o_mem_rdata, o_ram_addr, o_ram_wdata;
  logic [3:0]  o_ram_mask;
  int          n_vec = 0, n_err = 0;
  logic        saw_mem_rvalid;

  nnrv_ram_arb dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
    .i_mem_mask(i_mem_mask), .i_mem_wdata(i_mem_wdata), .o_mem_gnt(o_mem_gnt),
    .o_mem_rvalid(o_mem_rvalid), .o_mem_rdata(o_mem_rdata), .o_mem_stall(o_mem_stall),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_mask(o_ram_mask), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge o_mem_rvalid) saw_mem_rvalid = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_if_req = 1; i_mem_req = 1;
    #3;
    check("rst_if_rvalid", o_if_rvalid, 0);
    check("rst_mem_rvalid", o_mem_rvalid, 0);
    check("rst_mem_rdata", o_mem_rdata, 0);
    tick();
    check("rst_hold_rvalid", o_mem_rvalid, 0);
    i_rst_n = 1;
    #1;
    check("post_rst_mem_gnt", o_mem_gnt, 1);
    check("post_rst_if_gnt", o_if_gnt, 0);
    check("post_rst_if_stall", o_if_stall, 1);
    check("post_rst_mem_stall", o_mem_stall, 0);
    tick();
    i_if_req = 0; i_mem_req = 0; i_ram_rdata = 32'h0000_0055;
    #1;
    check("post_rst_mem_rvalid", o_mem_rvalid, 1);
    check("post_rst_mem_rdata", o_mem_rdata, 32'h55);
    check("post_rst_if_rdata0", o_if_rdata, 0);
    tick();
    // IF alone
    i_if_req = 1; i_if_addr = 32'h40;
    #1;
    check("if_gnt", o_if_gnt, 1);
    check("if_ram_en", o_ram_en, 1);
    check("if_ram_we", o_ram_we, 0);
    check("if_ram_addr", o_ram_addr, 32'h40);
    check("if_ram_mask", o_ram_mask, 4'hf);
    check("if_stall", o_if_stall, 0);
    tick();
    i_if_req = 0; i_ram_rdata = 32'hDEAD_BEEF;
    #1;
    check("if_rvalid", o_if_rvalid, 1);
    check("if_rdata", o_if_rdata, 32'hDEAD_BEEF);
    check("if_mem_rdata0", o_mem_rdata, 0);
    check("idle_ram_en", o_ram_en, 0);
    check("idle_ram_addr", o_ram_addr, 0);
    check("idle_ram_mask", o_ram_mask, 0);
    tick();
    // MEM load then store back-to-back
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h100; i_mem_mask = 4'b0011;
    i_mem_wdata = 32'hCAFE_F00D;
    #1;
    check("ld_gnt", o_mem_gnt, 1);
    check("ld_ram_addr", o_ram_addr, 32'h100);
    check("ld_ram_mask", o_ram_mask, 4'b0011);
    check("ld_ram_we", o_ram_we, 0);
    tick();
    i_mem_we = 1; i_mem_addr = 32'h104; i_mem_mask = 4'hf; i_mem_wdata = 32'h1234_5678;
    i_ram_rdata = 32'hA5A5_A5A5;
    #1;
    check("ld_rvalid", o_mem_rvalid, 1);
    check("ld_rdata", o_mem_rdata, 32'hA5A5_A5A5);
    check("ld_if_rvalid", o_if_rvalid, 0);
    check("st_gnt", o_mem_gnt, 1);
    check("st_ram_we", o_ram_we, 1);
    check("st_ram_addr", o_ram_addr, 32'h104);
    check("st_ram_wdata", o_ram_wdata, 32'h1234_5678);
    tick();
    i_mem_req = 0;
    #1;
    check("st_no_rvalid", o_mem_rvalid, 0);
    check("st_rdata0", o_mem_rdata, 0);
    tick();
    // continuous conflict: MEM four times, then IF
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h200; i_if_req = 1; i_if_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("starve_if_gnt%0d", k), o_if_gnt, (k % 5) == 4);
      check($sformatf("starve_mem_gnt%0d", k), o_mem_gnt, (k % 5) != 4);
      check($sformatf("starve_if_stall%0d", k), o_if_stall, (k % 5) != 4);
      check($sformatf("starve_mem_stall%0d", k), o_mem_stall, (k % 5) == 4);
      check($sformatf("starve_addr%0d", k), o_ram_addr, (k % 5) == 4 ? 32'h300 : 32'h200);
      tick();
    end
    i_mem_req = 0; i_if_req = 0;
    tick();
    // store with zero mask
    i_mem_req = 1; i_mem_we = 1; i_mem_mask = 4'b0000; i_mem_addr = 32'h108; i_mem_wdata = 32'hFFFF_FFFF;
    #1;
    check("st0_gnt", o_mem_gnt, 1);
    check("st0_stall", o_mem_stall, 0);
    check("st0_ram_en", o_ram_en, 0);
    check("st0_ram_we", o_ram_we, 0);
    check("st0_ram_wdata", o_ram_wdata, 0);
    tick();
    i_mem_req = 0; i_if_req = 1; i_if_addr = 32'h80;
    #1;
    check("st0_no_rvalid", o_mem_rvalid, 0);
    check("st0_if_gnt", o_if_gnt, 1);
    check("st0_if_addr", o_ram_addr, 32'h80);
    tick();
    i_if_req = 0; i_ram_rdata = 32'h0BAD_CAFE;
    #1;
    check("st0_if_rvalid", o_if_rvalid, 1);
    check("st0_if_rdata", o_if_rdata, 32'h0BAD_CAFE);
    tick();
    // async reset right after a load grant drops the response
    i_mem_req = 1; i_mem_we = 0; i_mem_mask = 4'hf; i_mem_addr = 32'h10C;
    #1;
    check("ar_ld_gnt", o_mem_gnt, 1);
    saw_mem_rvalid = 0;
    #2;
    i_rst_n = 0;
    #1;
    i_mem_req = 0;
    tick();
    check("ar_rvalid", o_mem_rvalid, 0);
    check("ar_rdata", o_mem_rdata, 0);
    #3;
    i_rst_n = 1;
    #1;
    check("ar_no_pulse", saw_mem_rvalid, 0);
    i_mem_req = 1; i_ram_rdata = 32'h7777_1111;
    #1;
    check("ar_post_gnt", o_mem_gnt, 1);
    tick();
    i_mem_req = 0;
    #1;
    check("ar_post_rvalid", o_mem_rvalid, 1);
    check("ar_post_rdata", o_mem_rdata, 32'h7777_1111);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
